// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared funct3 codes and M-stage FSM states
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/load_store_align.sv
// rtl/load_store_align.sv - store lane steering, byte enables, load extension, alignment fault
module load_store_align
    import riscv_mem_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] load_data,
    output logic        fault
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        case (addr_lo)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Loads always fetch the full word; only stores narrow the byte enables.
    always_comb begin
        wdata     = store_data;
        be        = 4'b1111;
        load_data = 32'd0;
        fault     = 1'b0;
        case (funct3)
            F3_B: begin
                wdata     = {4{store_data[7:0]}};
                load_data = {{24{lane_b[7]}}, lane_b};
                if (is_store) be = 4'b0001 << addr_lo;
            end
            F3_H: begin
                wdata     = {2{store_data[15:0]}};
                load_data = {{16{lane_h[15]}}, lane_h};
                if (is_store) be = addr_lo[1] ? 4'b1100 : 4'b0011;
                fault     = addr_lo[0];
            end
            F3_W: begin
                load_data = rdata;
                fault     = (addr_lo != 2'b00);
            end
            F3_BU: begin
                load_data = {24'd0, lane_b};
                fault     = is_store;
            end
            F3_HU: begin
                load_data = {16'd0, lane_h};
                fault     = is_store | addr_lo[0];
            end
            default: fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/memory_access_stage.sv
// rtl/memory_access_stage.sv - RV32I memory stage: data bus access, stall/timeout FSM, MEM/WB register
module memory_access_stage
    import riscv_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ValidM,
    input  logic        RegWriteM,
    input  logic        ResultSrcM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [4:0]  RdM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] PCPlus4M,
    output logic        StallM,
    output logic        DMemReq,
    output logic        DMemWe,
    output logic [31:0] DMemAddr,
    output logic [31:0] DMemWdata,
    output logic [3:0]  DMemBe,
    input  logic        DMemReady,
    input  logic [31:0] DMemRdata,
    output logic        ValidW,
    output logic        RegWriteW,
    output logic        ResultSrcW,
    output logic [4:0]  RdW,
    output logic [31:0] PCPlus4W,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic        ExceptionW
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    mem_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        valid_w_q, valid_w_d, reg_write_w_q, reg_write_w_d;
    logic        result_src_w_q, result_src_w_d, exception_w_q, exception_w_d;
    logic [4:0]  rd_w_q, rd_w_d;
    logic [31:0] pc_plus4_w_q, pc_plus4_w_d, alu_result_w_q, alu_result_w_d;
    logic [31:0] read_data_w_q, read_data_w_d;

    logic        mem_op, fault, req_raw, complete, abort, is_load;
    logic [31:0] load_data;

    load_store_align u_align (
        .is_store   (MemWriteM),
        .funct3     (Funct3M),
        .addr_lo    (ALUResultM[1:0]),
        .store_data (WriteDataM),
        .rdata      (DMemRdata),
        .wdata      (DMemWdata),
        .be         (DMemBe),
        .load_data  (load_data),
        .fault      (fault)
    );

    assign mem_op   = ValidM & (MemWriteM | ResultSrcM);
    assign is_load  = ResultSrcM & ~MemWriteM;
    assign req_raw  = ((state_q == S_IDLE) & mem_op & ~fault) | (state_q == S_WAIT);
    assign complete = req_raw & DMemReady;
    assign abort    = (state_q == S_WAIT) & ~DMemReady & (TIMEOUT != 0) & (cnt_q == CNT_LAST);

    assign DMemReq  = req_raw & ~rst;
    assign DMemWe   = MemWriteM;
    assign DMemAddr = {ALUResultM[31:2], 2'b00};
    assign StallM   = req_raw & ~DMemReady & ~abort;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (mem_op & ~fault & ~DMemReady) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (DMemReady | abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A stalled cycle inserts a bubble into W; data fields simply hold.
    always_comb begin
        valid_w_d      = 1'b0;
        reg_write_w_d  = 1'b0;
        exception_w_d  = 1'b0;
        result_src_w_d = result_src_w_q;
        rd_w_d         = rd_w_q;
        pc_plus4_w_d   = pc_plus4_w_q;
        alu_result_w_d = alu_result_w_q;
        read_data_w_d  = read_data_w_q;
        if (!StallM) begin
            exception_w_d  = (mem_op & fault) | abort;
            valid_w_d      = ValidM;
            reg_write_w_d  = ValidM & RegWriteM & ~exception_w_d;
            result_src_w_d = ResultSrcM;
            rd_w_d         = RdM;
            pc_plus4_w_d   = PCPlus4M;
            alu_result_w_d = ALUResultM;
            read_data_w_d  = (is_load & complete) ? load_data : 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            valid_w_q      <= 1'b0;
            reg_write_w_q  <= 1'b0;
            result_src_w_q <= 1'b0;
            exception_w_q  <= 1'b0;
            rd_w_q         <= 5'd0;
            pc_plus4_w_q   <= 32'd0;
            alu_result_w_q <= 32'd0;
            read_data_w_q  <= 32'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            valid_w_q      <= valid_w_d;
            reg_write_w_q  <= reg_write_w_d;
            result_src_w_q <= result_src_w_d;
            exception_w_q  <= exception_w_d;
            rd_w_q         <= rd_w_d;
            pc_plus4_w_q   <= pc_plus4_w_d;
            alu_result_w_q <= alu_result_w_d;
            read_data_w_q  <= read_data_w_d;
        end
    end

    assign ValidW     = valid_w_q;
    assign RegWriteW  = reg_write_w_q;
    assign ResultSrcW = result_src_w_q;
    assign ExceptionW = exception_w_q;
    assign RdW        = rd_w_q;
    assign PCPlus4W   = pc_plus4_w_q;
    assign ALUResultW = alu_result_w_q;
    assign ReadDataW  = read_data_w_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// tb/tb_memory_access_stage.sv - directed self-checking bench for memory_access_stage
module tb_memory_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ValidM, RegWriteM, ResultSrcM, MemWriteM;
    logic [2:0]  Funct3M;
    logic [4:0]  RdM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic        StallM, DMemReq, DMemWe;
    logic [31:0] DMemAddr, DMemWdata;
    logic [3:0]  DMemBe;
    logic        DMemReady;
    logic [31:0] DMemRdata;
    logic        ValidW, RegWriteW, ResultSrcW, ExceptionW;
    logic [4:0]  RdW;
    logic [31:0] PCPlus4W, ALUResultW, ReadDataW;

    int checks   = 0;
    int failures = 0;
    int stall_cnt;

    memory_access_stage #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .ValidM     (ValidM),
        .RegWriteM  (RegWriteM),
        .ResultSrcM (ResultSrcM),
        .MemWriteM  (MemWriteM),
        .Funct3M    (Funct3M),
        .RdM        (RdM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .PCPlus4M   (PCPlus4M),
        .StallM     (StallM),
        .DMemReq    (DMemReq),
        .DMemWe     (DMemWe),
        .DMemAddr   (DMemAddr),
        .DMemWdata  (DMemWdata),
        .DMemBe     (DMemBe),
        .DMemReady  (DMemReady),
        .DMemRdata  (DMemRdata),
        .ValidW     (ValidW),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .RdW        (RdW),
        .PCPlus4W   (PCPlus4W),
        .ALUResultW (ALUResultW),
        .ReadDataW  (ReadDataW),
        .ExceptionW (ExceptionW)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic rs, input logic mw,
                         input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                         input logic rdy, input logic [31:0] rd_word);
        ValidM     = v;
        RegWriteM  = rw;
        ResultSrcM = rs;
        MemWriteM  = mw;
        Funct3M    = f3;
        RdM        = 5'd9;
        ALUResultM = addr;
        WriteDataM = wd;
        PCPlus4M   = 32'h0000_0044;
        DMemReady  = rdy;
        DMemRdata  = rd_word;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 32'd0);
        tick();
        tick();
        check("rst_req", {31'd0, DMemReq}, 32'd0);
        check("rst_validw", {31'd0, ValidW}, 32'd0);
        check("rst_regwritew", {31'd0, RegWriteW}, 32'd0);
        check("rst_aluw", ALUResultW, 32'd0);
        check("rst_readw", ReadDataW, 32'd0);
        rst = 1'b0;

        // SW 0x100, zero wait
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 1'b1, 32'd0);
        check("sw_req", {31'd0, DMemReq}, 32'd1);
        check("sw_we", {31'd0, DMemWe}, 32'd1);
        check("sw_be", {28'd0, DMemBe}, 32'hF);
        check("sw_wdata", DMemWdata, 32'hDEAD_BEEF);
        check("sw_addr", DMemAddr, 32'h100);
        check("sw_stall", {31'd0, StallM}, 32'd0);
        tick();
        check("sw_validw", {31'd0, ValidW}, 32'd1);
        check("sw_regwritew", {31'd0, RegWriteW}, 32'd0);
        check("sw_excw", {31'd0, ExceptionW}, 32'd0);

        // LB 0x103, two wait cycles
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 1'b0, 32'h80FF_0000);
        check("lb_stall1", {31'd0, StallM}, 32'd1);
        check("lb_be", {28'd0, DMemBe}, 32'hF);
        check("lb_addr", DMemAddr, 32'h100);
        tick();
        check("lb_bubble1", {31'd0, ValidW}, 32'd0);
        check("lb_stall2", {31'd0, StallM}, 32'd1);
        check("lb_req_wait", {31'd0, DMemReq}, 32'd1);
        tick();
        check("lb_bubble2", {31'd0, ValidW}, 32'd0);
        DMemReady = 1'b1;
        #1;
        check("lb_stall3", {31'd0, StallM}, 32'd0);
        tick();
        check("lb_readw", ReadDataW, 32'hFFFF_FF80);
        check("lb_srcw", {31'd0, ResultSrcW}, 32'd1);
        check("lb_regwritew", {31'd0, RegWriteW}, 32'd1);
        check("lb_rdw", {27'd0, RdW}, 32'd9);

        // LHU 0x202, LH 0x202, LBU 0x101 zero wait
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b101, 32'h202, 32'd0, 1'b1, 32'hABCD_1234);
        check("lhu_stall", {31'd0, StallM}, 32'd0);
        tick();
        check("lhu_readw", ReadDataW, 32'h0000_ABCD);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b001, 32'h202, 32'd0, 1'b1, 32'h8001_7777);
        tick();
        check("lh_readw", ReadDataW, 32'hFFFF_8001);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b100, 32'h101, 32'd0, 1'b1, 32'h12AB_F456);
        tick();
        check("lbu_readw", ReadDataW, 32'h0000_00F4);

        // SB 0x201, SH 0x202
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h201, 32'h0000_005A, 1'b1, 32'd0);
        check("sb_be", {28'd0, DMemBe}, 32'h2);
        check("sb_wdata", DMemWdata, 32'h5A5A_5A5A);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_1234, 1'b1, 32'd0);
        check("sh_be", {28'd0, DMemBe}, 32'hC);
        check("sh_wdata", DMemWdata, 32'h1234_1234);
        tick();

        // Misaligned LW and illegal store funct3
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h102, 32'd0, 1'b0, 32'd0);
        check("lw_mis_req", {31'd0, DMemReq}, 32'd0);
        check("lw_mis_stall", {31'd0, StallM}, 32'd0);
        tick();
        check("lw_mis_excw", {31'd0, ExceptionW}, 32'd1);
        check("lw_mis_regwritew", {31'd0, RegWriteW}, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b100, 32'h100, 32'd0, 1'b0, 32'd0);
        check("st_ill_req", {31'd0, DMemReq}, 32'd0);
        tick();
        check("st_ill_excw", {31'd0, ExceptionW}, 32'd1);

        // Timeout: TIMEOUT=4, ready never comes
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 1'b0, 32'd0);
        stall_cnt = 0;
        while (StallM && stall_cnt < 12) begin
            stall_cnt++;
            tick();
        end
        check("to_stall_cycles", stall_cnt, 32'd4);
        tick();
        check("to_excw", {31'd0, ExceptionW}, 32'd1);
        check("to_regwritew", {31'd0, RegWriteW}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 32'd0);
        check("to_idle_req", {31'd0, DMemReq}, 32'd0);

        // Reset while waiting, then an ALU op
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h400, 32'd0, 1'b0, 32'd0);
        tick();
        check("rw_in_wait", {31'd0, StallM}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 32'd0);
        check("rw_req", {31'd0, DMemReq}, 32'd0);
        check("rw_stall", {31'd0, StallM}, 32'd0);
        check("rw_validw", {31'd0, ValidW}, 32'd0);
        check("rw_pcw", PCPlus4W, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'd7, 32'd0, 1'b0, 32'd0);
        check("alu_stall", {31'd0, StallM}, 32'd0);
        tick();
        check("alu_aluw", ALUResultW, 32'd7);
        check("alu_regwritew", {31'd0, RegWriteW}, 32'd1);
        check("alu_readw", ReadDataW, 32'd0);
        check("alu_pcw", PCPlus4W, 32'h44);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
